onn_inference_ctrl: RTL and testbench

Sequencer for one ONN inference. It loads an initial phase pattern into the oscillator array and lets the network run. It watches the 60-bit phase vector until the pattern has held still for a programmable number of sample windows, then drives `steady_cheak` so the phase-to-number decoder classifies it, and captures the 2-bit class. It sits between the host/test harness and the oscillator array plus decoder, and reports a timeout when the network never settles.

---
 rtl/onn_pkg.sv | 21 ++
 rtl/onn_inference_ctrl_steady_detector.sv | 44 ++++
 rtl/onn_inference_ctrl.sv | 145 ++++++++++++++
 tb/tb_onn_inference_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/onn_pkg.sv
// Shared definitions for the ONN inference sequencer: widths, FSM states and the
// digit phase patterns the decoder recognises.
package onn_pkg;

  localparam int N_OSC = 60;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DECODE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  localparam logic [N_OSC-1:0] DIGIT_00 = 60'h0F0F0F0F0F0F0F0;
  localparam logic [N_OSC-1:0] DIGIT_01 = 60'hFF00FF00FF00FF0;
  localparam logic [N_OSC-1:0] DIGIT_10 = 60'hAAAAAAAAAAAAAAA;
  localparam logic [1:0]       CLASS_UNKNOWN = 2'b11;

endpackage

// File: rtl/onn_inference_ctrl_steady_detector.sv
// Snapshot register plus comparator: flags the sample at which the phase vector
// has matched the previous snapshot STABLE_SAMPLES times in a row.
module onn_steady_detector import onn_pkg::*; #(
  parameter int STABLE_SAMPLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             sample,
  input  logic [N_OSC-1:0] phi,
  output logic             steady
);

  localparam int STW = $clog2(STABLE_SAMPLES) + 1;

  logic [N_OSC-1:0] snap_q;
  logic             snap_valid_q;
  logic [STW-1:0]   stable_q;
  logic             match;

  assign match  = snap_valid_q && (phi == snap_q);
  // Combinational so the FSM can leave RUN in the very sample that completes the run.
  assign steady = sample && match && (stable_q == STW'(STABLE_SAMPLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
      stable_q     <= '0;
    end else if (clear) begin
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
      stable_q     <= '0;
    end else if (sample) begin
      snap_q       <= phi;
      snap_valid_q <= 1'b1;
      if (!match)
        stable_q <= '0;
      else if (stable_q != STW'(STABLE_SAMPLES))
        stable_q <= stable_q + 1'b1;
    end
  end

endmodule

// File: rtl/onn_inference_ctrl.sv
// ONN inference sequencer: loads a phase pattern, runs the oscillator array until the
// phase vector settles (or times out), then strobes the decoder and captures its class.
module onn_inference_ctrl import onn_pkg::*; #(
  parameter int SAMPLE_DIV      = 16,
  parameter int STABLE_SAMPLES  = 4,
  parameter int TIMEOUT_SAMPLES = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [N_OSC-1:0] pattern_in,
  input  logic [N_OSC-1:0] phi_out,
  input  logic [1:0]       num,
  output logic [N_OSC-1:0] osc_init,
  output logic             osc_load,
  output logic             osc_run,
  output logic             steady_cheak,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [1:0]       result
);

  // state      | meaning
  // ST_IDLE    | waiting for start
  // ST_LOAD    | osc_load pulse, pattern enters the array
  // ST_RUN     | oscillators free-running, phase sampled once per window
  // ST_DECODE  | decoder enabled, oscillators still running
  // ST_CAPTURE | decoder output valid, captured into result
  // ST_DONE    | done pulse

  localparam int WCW = $clog2(SAMPLE_DIV) + 1;
  localparam int SCW = $clog2(TIMEOUT_SAMPLES) + 1;

  state_t         state_q, state_d;
  logic [WCW-1:0] win_cnt_q;
  logic [SCW-1:0] samp_cnt_q;
  logic           accept;
  logic           sample_tick;
  logic           steady;
  logic           abortable;

  assign accept      = (state_q == ST_IDLE) && start;
  assign sample_tick = (state_q == ST_RUN) && (win_cnt_q == WCW'(SAMPLE_DIV - 1));
  assign abortable   = (state_q == ST_LOAD) || (state_q == ST_RUN) ||
                       (state_q == ST_DECODE) || (state_q == ST_CAPTURE);

  onn_steady_detector #(
    .STABLE_SAMPLES(STABLE_SAMPLES)
  ) u_steady (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .sample (sample_tick),
    .phi    (phi_out),
    .steady (steady)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start) state_d = ST_LOAD;
      ST_LOAD:    state_d = ST_RUN;
      ST_RUN: begin
        if (sample_tick) begin
          if (steady)
            state_d = ST_DECODE;
          else if (samp_cnt_q == SCW'(TIMEOUT_SAMPLES - 1))
            state_d = ST_DONE;
        end
      end
      ST_DECODE:  state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (abort && abortable) state_d = ST_IDLE;
  end

  always_comb begin
    osc_load     = 1'b0;
    osc_run      = 1'b0;
    steady_cheak = 1'b0;
    busy         = (state_q != ST_IDLE);
    done         = 1'b0;
    unique case (state_q)
      ST_LOAD:    osc_load = 1'b1;
      ST_RUN:     osc_run = 1'b1;
      ST_DECODE: begin
        osc_run      = 1'b1;
        steady_cheak = 1'b1;
      end
      ST_CAPTURE: steady_cheak = 1'b1;
      ST_DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q  <= '0;
      samp_cnt_q <= '0;
    end else if (accept) begin
      win_cnt_q  <= '0;
      samp_cnt_q <= '0;
    end else if (state_q == ST_RUN) begin
      if (sample_tick) begin
        win_cnt_q  <= '0;
        samp_cnt_q <= samp_cnt_q + 1'b1;
      end else begin
        win_cnt_q  <= win_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      osc_init <= '0;
    else if (accept)
      osc_init <= pattern_in;
    else if (abort && abortable)
      osc_init <= '0;
  end

  // result/timeout change only on a real completion; an abort leaves them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result  <= 2'b00;
      timeout <= 1'b0;
    end else if (state_q == ST_CAPTURE && state_d == ST_DONE) begin
      result  <= num;
      timeout <= 1'b0;
    end else if (state_q == ST_RUN && state_d == ST_DONE) begin
      result  <= CLASS_UNKNOWN;
      timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_onn_inference_ctrl.sv
// Directed and randomized bench for onn_inference_ctrl with a window-level reference
// model of settling, timeout, abort and reset behaviour.
module tb_onn_inference_ctrl;
  import onn_pkg::*;

  localparam int SD = 16;
  localparam int SS = 4;
  localparam int TO = 256;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [N_OSC-1:0] pattern_in = '0;
  logic [N_OSC-1:0] phi_out = '0;
  logic [1:0]       num = 2'b10;
  logic [N_OSC-1:0] osc_init;
  logic             osc_load, osc_run, steady_cheak, busy, done, timeout;
  logic [1:0]       result;

  int n_tests = 0;
  int n_fail  = 0;

  logic [N_OSC-1:0] seq [0:TO+8];
  logic             sc_last = 1'b0;
  logic [N_OSC-1:0] phi_last = '0;

  always #5 clk = ~clk;

  onn_inference_ctrl #(
    .SAMPLE_DIV(SD), .STABLE_SAMPLES(SS), .TIMEOUT_SAMPLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .pattern_in(pattern_in), .phi_out(phi_out), .num(num),
    .osc_init(osc_init), .osc_load(osc_load), .osc_run(osc_run),
    .steady_cheak(steady_cheak), .busy(busy), .done(done),
    .timeout(timeout), .result(result)
  );

  function automatic logic [1:0] ref_class(input logic [N_OSC-1:0] v);
    if (v == DIGIT_00) return 2'b00;
    if (v == DIGIT_01) return 2'b01;
    if (v == DIGIT_10) return 2'b10;
    return 2'b11;
  endfunction

  function automatic logic [N_OSC-1:0] rnd_vec();
    return N_OSC'({$urandom(), $urandom()});
  endfunction

  function automatic logic [N_OSC-1:0] pick();
    case ($urandom_range(0, 3))
      0: return DIGIT_00;
      1: return DIGIT_01;
      2: return DIGIT_10;
      default: return rnd_vec();
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decoder model: num latches the class of phi_out at the end of any cycle with steady_cheak.
  task automatic tick();
    sc_last  = steady_cheak;
    phi_last = phi_out;
    @(posedge clk);
    #1;
    if (sc_last) num = ref_class(phi_last);
  endtask

  task automatic fill_const(input logic [N_OSC-1:0] v);
    for (int w = 0; w <= TO + 8; w++) seq[w] = v;
  endtask

  task automatic fill_toggle(input logic [N_OSC-1:0] a, input logic [N_OSC-1:0] b, input int t);
    for (int w = 0; w <= TO + 8; w++)
      seq[w] = (w < t) ? ((w % 2 == 1) ? a : b) : seq[t-1];
  endtask

  // Sample k (k>=1) sees the value held during window k-1; steady once SS matches in a row.
  task automatic predict(output int d, output logic [1:0] r, output logic t);
    int cnt;
    cnt = 0;
    d = 2 + TO * SD;
    r = 2'b11;
    t = 1'b1;
    for (int k = 1; k <= TO; k++) begin
      if (k > 1 && seq[k-1] == seq[k-2]) cnt++;
      else cnt = 0;
      if (cnt == SS) begin
        d = 4 + k * SD;
        r = ref_class(seq[k]);
        t = 1'b0;
        break;
      end
    end
  endtask

  task automatic run_one(input string name, input logic [N_OSC-1:0] pat,
                         input int abort_at, input int rst_at, input bit noise);
    int d, last, seen_done;
    logic [1:0] er, pr;
    logic et, pt;
    logic [4:0] ctl_e;
    predict(d, er, et);
    pr = result;
    pt = timeout;
    tick();
    chk({name, "-idle"}, {busy, done}, 2'b00);
    chk({name, "-held"}, {timeout, result}, {pt, pr});
    start = 1'b1;
    abort = 1'b0;
    pattern_in = pat;
    phi_out = rnd_vec();
    num = 2'($urandom_range(0, 3));
    last = (abort_at > 0) ? abort_at : ((rst_at > 0) ? rst_at : d);
    for (int c = 1; c <= last; c++) begin
      tick();
      start = (noise && c >= 2 && c < d - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      abort = (c == abort_at);
      pattern_in = rnd_vec();
      phi_out = (c < 2) ? seq[0] : seq[(c - 2) / SD];
      ctl_e[4] = (c >= 1 && c <= d);
      ctl_e[3] = (c == 1);
      ctl_e[2] = et ? (c >= 2 && c <= d - 1) : (c >= 2 && c <= d - 2);
      ctl_e[1] = !et && (c == d - 2 || c == d - 1);
      ctl_e[0] = (c == d);
      chk($sformatf("%s-ctl@%0d", name, c), {busy, osc_load, osc_run, steady_cheak, done}, ctl_e);
      chk($sformatf("%s-init@%0d", name, c), osc_init, pat);
      if (c == d) chk({name, "-result"}, {timeout, result}, {et, er});
    end
    start = 1'b0;
    if (abort_at > 0) begin
      tick();
      abort = 1'b0;
      chk({name, "-abort-out"}, {busy, osc_load, osc_run, steady_cheak, done}, 5'b0);
      chk({name, "-abort-held"}, {timeout, result}, {pt, pr});
      seen_done = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (done || busy) seen_done++;
      end
      chk({name, "-abort-quiet"}, seen_done, 0);
    end else if (rst_at > 0) begin
      rst_n = 1'b0;
      #1;
      chk({name, "-rst-ctl"}, {busy, osc_load, osc_run, steady_cheak, done, timeout, result}, 7'b0);
      chk({name, "-rst-init"}, osc_init, 0);
      tick();
      tick();
      rst_n = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset-ctl", {busy, osc_load, osc_run, steady_cheak, done, timeout, result}, 7'b0);
    chk("reset-init", osc_init, 0);
    rst_n = 1'b1;

    fill_const(DIGIT_01);
    run_one("settle", DIGIT_00, 0, 0, 1'b0);

    fill_toggle(DIGIT_10, DIGIT_00, 10);
    run_one("late", DIGIT_01, 0, 0, 1'b0);

    for (int w = 0; w <= TO + 8; w++) seq[w] = (w < 4) ? DIGIT_00 : DIGIT_10;
    run_one("restart", DIGIT_01, 0, 0, 1'b0);

    fill_toggle(DIGIT_01, DIGIT_10, TO + 8);
    run_one("timeout", DIGIT_00, 0, 0, 1'b0);

    fill_const(DIGIT_10);
    run_one("abort40", DIGIT_01, 40, 0, 1'b0);
    run_one("abort-load", DIGIT_01, 1, 0, 1'b0);
    run_one("abort-dec", DIGIT_01, 82, 0, 1'b0);
    run_one("abort-cap", DIGIT_01, 83, 0, 1'b0);
    run_one("reissue", DIGIT_00, 0, 0, 1'b1);

    fill_const(DIGIT_01);
    run_one("rst50", DIGIT_10, 0, 50, 1'b0);
    fill_const(DIGIT_00);
    run_one("post-rst", DIGIT_01, 0, 0, 1'b0);

    fill_const(rnd_vec());
    run_one("unknown", DIGIT_10, 0, 0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      int t;
      t = $urandom_range(1, 20);
      for (int w = 0; w <= TO + 8; w++) seq[w] = (w < t) ? pick() : seq[t-1];
      run_one($sformatf("rand%0d", r), rnd_vec(), 0, 0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
